// File: rtl/zone_sequence_req.sv
// zone_sequence_req: ordered zone-visit requirement monitor for the maze harness.
// Tracks NUM_ZONES zones visited in strict order, with an absorbing trap zone,
// an optional strict no-skip mode (STRICT) and an optional step-budget error
// compiled in when the macro ZONE_SEQ_STEP_BUDGET_EN is defined.
module zone_sequence_req #(
   parameter int  NUM_ZONES = 5,
   parameter int  STRICT    = 0,
   parameter int  MAX_STEPS = 64,
   localparam int STAGE_W   = $clog2(NUM_ZONES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iupdown,
   input  logic                 ileftright,
   input  logic [NUM_ZONES-1:0] controllable_zone,
   input  logic                 controllable_trap,
   output logic                 error,
   output logic                 objective,
   output logic                 trapped,
   output logic [STAGE_W-1:0]   stage
);

   localparam logic [STAGE_W-1:0] STAGE_DONE = STAGE_W'(NUM_ZONES);

   logic               armed_q,   armed_d;
   logic               trapped_q, trapped_d;
   logic [STAGE_W-1:0] stage_q,   stage_d;
   logic               done;
   logic               hit_next;
   logic               hit_skip;
   logic               unused_inputs;

   // Move inputs belong to the environment model; the monitor never looks at them.
   assign unused_inputs = &{1'b0, iupdown, ileftright};

   assign done = (stage_q == STAGE_DONE);

   // Classify asserted zone bits against the current stage: expected vs. beyond it.
   always_comb begin
      hit_next = 1'b0;
      hit_skip = 1'b0;
      for (int j = 0; j < NUM_ZONES; j++) begin
         if (controllable_zone[j]) begin
            if (STAGE_W'(j) == stage_q) hit_next = 1'b1;
            if (STAGE_W'(j) >  stage_q) hit_skip = 1'b1;
         end
      end
   end

   // Next-state: arming edge ignores inputs; then trap > strict skip > advance > hold.
   always_comb begin
      armed_d   = 1'b1;
      trapped_d = trapped_q;
      stage_d   = stage_q;
      if (armed_q && !done && !trapped_q) begin
         if (controllable_trap) begin
            trapped_d = 1'b1;
         end else if ((STRICT != 0) && hit_skip) begin
            trapped_d = 1'b1;
         end else if (hit_next) begin
            stage_d = stage_q + STAGE_W'(1);
         end
      end
   end

   // Monitor state registers with asynchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed_q   <= 1'b0;
         trapped_q <= 1'b0;
         stage_q   <= '0;
      end else begin
         armed_q   <= armed_d;
         trapped_q <= trapped_d;
         stage_q   <= stage_d;
      end
   end

   assign objective = done & ~trapped_q;
   assign trapped   = trapped_q;
   assign stage     = stage_q;

`ifdef ZONE_SEQ_STEP_BUDGET_EN
   localparam int               CNT_W      = $clog2(MAX_STEPS + 1);
   localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);

   logic [CNT_W-1:0] steps_q,      steps_d;
   logic             budget_err_q, budget_err_d;

   // Count armed searching cycles; flag exhaustion unless the objective lands on that edge.
   always_comb begin
      steps_d      = steps_q;
      budget_err_d = budget_err_q;
      if (armed_q && !done && !trapped_q && (steps_q != STEP_LIMIT)) begin
         steps_d = steps_q + CNT_W'(1);
         if ((steps_d == STEP_LIMIT) && (stage_d != STAGE_DONE)) begin
            budget_err_d = 1'b1;
         end
      end
   end

   // Step counter and sticky budget error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         steps_q      <= '0;
         budget_err_q <= 1'b0;
      end else begin
         steps_q      <= steps_d;
         budget_err_q <= budget_err_d;
      end
   end

   assign error = trapped_q | budget_err_q;
`else
   logic unused_budget;

   // Without the budget feature the step limit has no consumer.
   assign unused_budget = (MAX_STEPS > 0);
   assign error         = trapped_q;
`endif

endmodule

// File: tb/tb_zone_sequence_req.sv
// tb_zone_sequence_req: table-driven and hand-sequenced checks of zone_sequence_req
// (NUM_ZONES=4, MAX_STEPS=8) with a STRICT=0 and a STRICT=1 instance on shared inputs.
module tb_zone_sequence_req;

   localparam int NZ = 4;
   localparam int SW = 3;
`ifdef ZONE_SEQ_STEP_BUDGET_EN
   localparam bit BUDGET = 1'b1;
`else
   localparam bit BUDGET = 1'b0;
`endif

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          iupdown    = 1'b0;
   logic          ileftright = 1'b0;
   logic [NZ-1:0] zone       = '0;
   logic          trap       = 1'b0;

   logic          error,   objective,   trapped;
   logic [SW-1:0] stage;
   logic          s_error, s_objective, s_trapped;
   logic [SW-1:0] s_stage;

   int n_checks = 0;
   int n_errors = 0;

   // Expected-output word: {stage[2:0], trapped, objective, error}.
   typedef struct {
      logic          rst;
      logic [NZ-1:0] zone;
      logic          trap;
      logic [5:0]    exp_v;
   } vec_t;

   vec_t       tbl[$];
   logic [5:0] sb_main[$];
   logic [5:0] sb_strict[$];

   zone_sequence_req #(.NUM_ZONES(NZ), .STRICT(0), .MAX_STEPS(8)) dut (
      .clk(clk), .rst(rst), .iupdown(iupdown), .ileftright(ileftright),
      .controllable_zone(zone), .controllable_trap(trap),
      .error(error), .objective(objective), .trapped(trapped), .stage(stage)
   );

   zone_sequence_req #(.NUM_ZONES(NZ), .STRICT(1), .MAX_STEPS(8)) dut_s (
      .clk(clk), .rst(rst), .iupdown(iupdown), .ileftright(ileftright),
      .controllable_zone(zone), .controllable_trap(trap),
      .error(s_error), .objective(s_objective), .trapped(s_trapped), .stage(s_stage)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ex(input int st, input bit tr, input bit ob, input bit er);
      return {3'(st), tr, ob, er};
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got stage=%0d trapped=%b objective=%b error=%b, expected stage=%0d trapped=%b objective=%b error=%b",
                  name, act[5:3], act[2], act[1], act[0], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
      end
   endtask

   // Drive one cycle of stimulus, queue expectations, compare just after the edge.
   task automatic step(input logic r, input logic [NZ-1:0] z, input logic t,
                       input logic [5:0] exp_m, input logic [5:0] exp_s,
                       input bit chk_s, input string name);
      logic [5:0] e;
      @(negedge clk);
      rst  = r;
      zone = z;
      trap = t;
      sb_main.push_back(exp_m);
      if (chk_s) sb_strict.push_back(exp_s);
      @(posedge clk);
      #1;
      e = sb_main.pop_front();
      check(name, {stage, trapped, objective, error}, e);
      if (chk_s) begin
         e = sb_strict.pop_front();
         check({name, "_strict"}, {s_stage, s_trapped, s_objective, s_error}, e);
      end
   endtask

   task automatic add(input logic r, input logic [NZ-1:0] z, input logic t, input logic [5:0] e);
      vec_t v;
      v.rst = r; v.zone = z; v.trap = t; v.exp_v = e;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // In-order visit
      add(1, 4'b0000, 0, ex(0, 0, 0, 0));
      add(0, 4'b0000, 0, ex(0, 0, 0, 0));
      add(0, 4'b0001, 0, ex(1, 0, 0, 0));
      add(0, 4'b0010, 0, ex(2, 0, 0, 0));
      add(0, 4'b0100, 0, ex(3, 0, 0, 0));
      add(0, 4'b1000, 0, ex(4, 0, 1, 0));
      add(0, 4'b0000, 0, ex(4, 0, 1, 0));
      add(0, 4'b0000, 0, ex(4, 0, 1, 0));
      // Arming edge ignores zone, then one advance per edge, no wrap
      add(1, 4'b0000, 0, ex(0, 0, 0, 0));
      add(0, 4'b0001, 0, ex(0, 0, 0, 0));
      add(0, 4'b0001, 0, ex(1, 0, 0, 0));
      add(0, 4'b1111, 0, ex(2, 0, 0, 0));
      add(0, 4'b1111, 0, ex(3, 0, 0, 0));
      add(0, 4'b1111, 0, ex(4, 0, 1, 0));
      add(0, 4'b1111, 0, ex(4, 0, 1, 0));
      // Trap priority and absorption, then mid-run reset
      add(1, 4'b0000, 0, ex(0, 0, 0, 0));
      add(0, 4'b0000, 0, ex(0, 0, 0, 0));
      add(0, 4'b0001, 0, ex(1, 0, 0, 0));
      add(0, 4'b0010, 0, ex(2, 0, 0, 0));
      add(0, 4'b0100, 1, ex(2, 1, 0, 1));
      add(0, 4'b0100, 0, ex(2, 1, 0, 1));
      add(0, 4'b1000, 0, ex(2, 1, 0, 1));
      add(0, 4'b0000, 1, ex(2, 1, 0, 1));
      add(1, 4'b0100, 0, ex(0, 0, 0, 0));
      // Non-strict: skipped and lower bits ignored, expected bit still advances
      add(0, 4'b0000, 0, ex(0, 0, 0, 0));
      add(0, 4'b0001, 0, ex(1, 0, 0, 0));
      add(0, 4'b0100, 0, ex(1, 0, 0, 0));
      add(0, 4'b1010, 0, ex(2, 0, 0, 0));
      add(0, 4'b0011, 0, ex(2, 0, 0, 0));
      add(1, 4'b0000, 0, ex(0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].zone, tbl[i].trap, tbl[i].exp_v, '0, 1'b0,
              $sformatf("tbl[%0d]", i));
      end

      // Asynchronous reset clears a trapped monitor without waiting for a clock edge
      step(0, 4'b0000, 0, ex(0, 0, 0, 0), '0, 1'b0, "async_arm");
      step(0, 4'b0000, 1, ex(0, 1, 0, 1), '0, 1'b0, "async_trap");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_reset", {stage, trapped, objective, error}, ex(0, 0, 0, 0));

      // Strict skip: STRICT=1 traps on zone beyond expected, STRICT=0 ignores it
      step(1, 4'b0000, 0, ex(0, 0, 0, 0), ex(0, 0, 0, 0), 1'b1, "strict_rst");
      step(0, 4'b0000, 0, ex(0, 0, 0, 0), ex(0, 0, 0, 0), 1'b1, "strict_arm");
      step(0, 4'b0001, 0, ex(1, 0, 0, 0), ex(1, 0, 0, 0), 1'b1, "strict_z1");
      step(0, 4'b0100, 0, ex(1, 0, 0, 0), ex(1, 1, 0, 1), 1'b1, "strict_skip");
      step(0, 4'b0010, 0, ex(2, 0, 0, 0), ex(1, 1, 0, 1), 1'b1, "strict_absorb");

      // Strict in-order with lower bits still set never traps
      step(1, 4'b0000, 0, ex(0, 0, 0, 0), ex(0, 0, 0, 0), 1'b1, "strict2_rst");
      step(0, 4'b0000, 0, ex(0, 0, 0, 0), ex(0, 0, 0, 0), 1'b1, "strict2_arm");
      step(0, 4'b0001, 0, ex(1, 0, 0, 0), ex(1, 0, 0, 0), 1'b1, "strict2_z1");
      step(0, 4'b0011, 0, ex(2, 0, 0, 0), ex(2, 0, 0, 0), 1'b1, "strict2_z2");
      step(0, 4'b0111, 0, ex(3, 0, 0, 0), ex(3, 0, 0, 0), 1'b1, "strict2_z3");
      step(0, 4'b1111, 0, ex(4, 0, 1, 0), ex(4, 0, 1, 0), 1'b1, "strict2_z4");

      // Budget: idle armed cycles; error only with the feature, from the 8th edge on
      step(1, 4'b0000, 0, ex(0, 0, 0, 0), '0, 1'b0, "budget_rst");
      step(0, 4'b0000, 0, ex(0, 0, 0, 0), '0, 1'b0, "budget_arm");
      for (int i = 1; i <= 10; i++) begin
         step(0, 4'b0000, 0, ex(0, 0, 0, BUDGET && (i >= 8)), '0, 1'b0,
              $sformatf("budget_idle%0d", i));
      end

      // Budget: objective reached on the 8th armed edge wins over the budget error
      step(1, 4'b0000, 0, ex(0, 0, 0, 0), '0, 1'b0, "race_rst");
      step(0, 4'b0000, 0, ex(0, 0, 0, 0), '0, 1'b0, "race_arm");
      for (int i = 1; i <= 4; i++) begin
         step(0, 4'b0000, 0, ex(0, 0, 0, 0), '0, 1'b0, $sformatf("race_idle%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         logic [NZ-1:0] z;
         z = '0;
         z[i] = 1'b1;
         step(0, z, 0, ex(i + 1, 0, i == 3, 0), '0, 1'b0, $sformatf("race_zone%0d", i + 1));
      end
      for (int i = 1; i <= 3; i++) begin
         step(0, 4'b0000, 0, ex(4, 0, 1, 0), '0, 1'b0, $sformatf("race_hold%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
